axi4_write_downsizer: RTL and testbench

- AXI4 write-path width converter, 128-bit slave side to 64-bit master side. It is the counterpart of the 64-to-128 straddle upsizer.
- Accepts one full-width INCR write burst at a time.
- Re-issues the burst on the narrow master port with doubled length, splitting each wide W beat into two narrow beats, low half first.
- The B response is returned with the original ID.
- Illegal bursts are absorbed locally and answered with SLVERR.

---
 rtl/axi4_write_downsizer.sv | 210 +++++++++++++++++++++
 tb/tb_axi4_write_downsizer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_write_downsizer.sv
// AXI4 write-path width converter: one 128-bit INCR burst at a time is re-issued on a
// 64-bit master port with doubled length, each wide beat split low half first.
module axi4_write_downsizer #(
    parameter int C_S_AXI_ID_WIDTH   = 4,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int C_S_AXI_DATA_WIDTH = 128,
    parameter int C_M_AXI_DATA_WIDTH = 64
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,

    input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [7:0]                      S_AXI_AWLEN,
    input  logic [2:0]                      S_AXI_AWSIZE,
    input  logic [1:0]                      S_AXI_AWBURST,
    input  logic                            S_AXI_AWLOCK,
    input  logic [3:0]                      S_AXI_AWCACHE,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic [3:0]                      S_AXI_AWQOS,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WLAST,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,

    output logic [C_S_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
    output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
    output logic [7:0]                      M_AXI_AWLEN,
    output logic [2:0]                      M_AXI_AWSIZE,
    output logic [1:0]                      M_AXI_AWBURST,
    output logic                            M_AXI_AWLOCK,
    output logic [3:0]                      M_AXI_AWCACHE,
    output logic [2:0]                      M_AXI_AWPROT,
    output logic [3:0]                      M_AXI_AWQOS,
    output logic                            M_AXI_AWVALID,
    input  logic                            M_AXI_AWREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
    output logic                            M_AXI_WLAST,
    output logic                            M_AXI_WVALID,
    input  logic                            M_AXI_WREADY,
    input  logic [C_S_AXI_ID_WIDTH-1:0]     M_AXI_BID,
    input  logic [1:0]                      M_AXI_BRESP,
    input  logic                            M_AXI_BVALID,
    output logic                            M_AXI_BREADY
);

    localparam int MW = C_M_AXI_DATA_WIDTH;
    localparam int MS = C_M_AXI_DATA_WIDTH / 8;

    typedef enum logic [2:0] {IDLE, ADDR, DATA, RESP, DRAIN, ERESP} state_t;

    state_t state, state_nxt;

    logic                            rst_done;
    logic [C_S_AXI_ID_WIDTH-1:0]     aw_id_q;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [7:0]                      aw_len_q;
    logic [2:0]                      aw_size_q;
    logic [1:0]                      aw_burst_q;
    logic                            aw_lock_q;
    logic [3:0]                      aw_cache_q;
    logic [2:0]                      aw_prot_q;
    logic [3:0]                      aw_qos_q;

    logic [C_S_AXI_DATA_WIDTH-1:0]   wdata_q;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] wstrb_q;
    logic                            wlast_q;
    logic                            full_q;
    logic                            half_q;

    logic aw_hs, w_load, mw_hs, burst_ok;

    assign aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_load   = S_AXI_WVALID && S_AXI_WREADY && (state == DATA);
    assign mw_hs    = M_AXI_WVALID && M_AXI_WREADY;
    assign burst_ok = (S_AXI_AWSIZE == 3'd4) && (S_AXI_AWBURST == 2'b01) &&
                      (S_AXI_AWADDR[3:0] == 4'd0) && !S_AXI_AWLEN[7];

    // AWREADY is held low for the first cycle out of reset so it reads 0 during reset
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state    <= IDLE;
            rst_done <= 1'b0;
        end else begin
            state    <= state_nxt;
            rst_done <= 1'b1;
        end
    end

    always_comb begin
        state_nxt     = state;
        S_AXI_AWREADY = 1'b0;
        S_AXI_WREADY  = 1'b0;
        S_AXI_BVALID  = 1'b0;
        S_AXI_BID     = aw_id_q;
        S_AXI_BRESP   = 2'b00;
        M_AXI_AWVALID = 1'b0;
        M_AXI_WVALID  = 1'b0;
        M_AXI_BREADY  = 1'b0;
        case (state)
            IDLE: begin
                S_AXI_AWREADY = rst_done;
                if (S_AXI_AWVALID && rst_done)
                    state_nxt = burst_ok ? ADDR : DRAIN;
            end
            ADDR: begin
                M_AXI_AWVALID = 1'b1;
                if (M_AXI_AWREADY)
                    state_nxt = DATA;
            end
            DATA: begin
                S_AXI_WREADY = !full_q;
                M_AXI_WVALID = full_q;
                if (full_q && half_q && wlast_q && M_AXI_WREADY)
                    state_nxt = RESP;
            end
            RESP: begin
                S_AXI_BVALID = M_AXI_BVALID;
                M_AXI_BREADY = S_AXI_BREADY;
                S_AXI_BID    = M_AXI_BID;
                S_AXI_BRESP  = M_AXI_BRESP;
                if (M_AXI_BVALID && S_AXI_BREADY)
                    state_nxt = IDLE;
            end
            DRAIN: begin
                S_AXI_WREADY = 1'b1;
                if (S_AXI_WVALID && S_AXI_WLAST)
                    state_nxt = ERESP;
            end
            ERESP: begin
                S_AXI_BVALID = 1'b1;
                S_AXI_BRESP  = 2'b10;
                if (S_AXI_BREADY)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_lock_q  <= 1'b0;
            aw_cache_q <= '0;
            aw_prot_q  <= '0;
            aw_qos_q   <= '0;
        end else if (aw_hs) begin
            aw_id_q    <= S_AXI_AWID;
            aw_addr_q  <= S_AXI_AWADDR;
            aw_len_q   <= {S_AXI_AWLEN[6:0], 1'b1};
            aw_size_q  <= 3'd3;
            aw_burst_q <= 2'b01;
            aw_lock_q  <= S_AXI_AWLOCK;
            aw_cache_q <= S_AXI_AWCACHE;
            aw_prot_q  <= S_AXI_AWPROT;
            aw_qos_q   <= S_AXI_AWQOS;
        end
    end

    // Wide beat buffer: load only when empty, so S_WREADY never depends on M_WREADY
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            wdata_q <= '0;
            wstrb_q <= '0;
            wlast_q <= 1'b0;
            full_q  <= 1'b0;
            half_q  <= 1'b0;
        end else if (w_load) begin
            wdata_q <= S_AXI_WDATA;
            wstrb_q <= S_AXI_WSTRB;
            wlast_q <= S_AXI_WLAST;
            full_q  <= 1'b1;
            half_q  <= 1'b0;
        end else if (mw_hs) begin
            if (half_q) begin
                full_q <= 1'b0;
                half_q <= 1'b0;
            end else begin
                half_q <= 1'b1;
            end
        end
    end

    assign M_AXI_AWID    = aw_id_q;
    assign M_AXI_AWADDR  = aw_addr_q;
    assign M_AXI_AWLEN   = aw_len_q;
    assign M_AXI_AWSIZE  = aw_size_q;
    assign M_AXI_AWBURST = aw_burst_q;
    assign M_AXI_AWLOCK  = aw_lock_q;
    assign M_AXI_AWCACHE = aw_cache_q;
    assign M_AXI_AWPROT  = aw_prot_q;
    assign M_AXI_AWQOS   = aw_qos_q;

    assign M_AXI_WDATA   = half_q ? wdata_q[2*MW-1:MW] : wdata_q[MW-1:0];
    assign M_AXI_WSTRB   = half_q ? wstrb_q[2*MS-1:MS] : wstrb_q[MS-1:0];
    assign M_AXI_WLAST   = wlast_q && half_q;

endmodule

// File: tb/tb_axi4_write_downsizer.sv
// Directed bench for axi4_write_downsizer: legal bursts, strobe handling, SLVERR path,
// response back-pressure and mid-burst reset.
`timescale 1ns/1ps
module tb_axi4_write_downsizer;

    logic         ACLK = 1'b0;
    logic         ARESETN;
    logic [3:0]   S_AXI_AWID;
    logic [31:0]  S_AXI_AWADDR;
    logic [7:0]   S_AXI_AWLEN;
    logic [2:0]   S_AXI_AWSIZE;
    logic [1:0]   S_AXI_AWBURST;
    logic         S_AXI_AWLOCK;
    logic [3:0]   S_AXI_AWCACHE;
    logic [2:0]   S_AXI_AWPROT;
    logic [3:0]   S_AXI_AWQOS;
    logic         S_AXI_AWVALID;
    logic         S_AXI_AWREADY;
    logic [127:0] S_AXI_WDATA;
    logic [15:0]  S_AXI_WSTRB;
    logic         S_AXI_WLAST;
    logic         S_AXI_WVALID;
    logic         S_AXI_WREADY;
    logic [3:0]   S_AXI_BID;
    logic [1:0]   S_AXI_BRESP;
    logic         S_AXI_BVALID;
    logic         S_AXI_BREADY;
    logic [3:0]   M_AXI_AWID;
    logic [31:0]  M_AXI_AWADDR;
    logic [7:0]   M_AXI_AWLEN;
    logic [2:0]   M_AXI_AWSIZE;
    logic [1:0]   M_AXI_AWBURST;
    logic         M_AXI_AWLOCK;
    logic [3:0]   M_AXI_AWCACHE;
    logic [2:0]   M_AXI_AWPROT;
    logic [3:0]   M_AXI_AWQOS;
    logic         M_AXI_AWVALID;
    logic         M_AXI_AWREADY;
    logic [63:0]  M_AXI_WDATA;
    logic [7:0]   M_AXI_WSTRB;
    logic         M_AXI_WLAST;
    logic         M_AXI_WVALID;
    logic         M_AXI_WREADY;
    logic [3:0]   M_AXI_BID;
    logic [1:0]   M_AXI_BRESP;
    logic         M_AXI_BVALID;
    logic         M_AXI_BREADY;

    always #5 ACLK = ~ACLK;

    axi4_write_downsizer dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWID(S_AXI_AWID), .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWSIZE(S_AXI_AWSIZE), .S_AXI_AWBURST(S_AXI_AWBURST), .S_AXI_AWLOCK(S_AXI_AWLOCK),
        .S_AXI_AWCACHE(S_AXI_AWCACHE), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWQOS(S_AXI_AWQOS),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WLAST(S_AXI_WLAST),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BID(S_AXI_BID), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
        .S_AXI_BREADY(S_AXI_BREADY),
        .M_AXI_AWID(M_AXI_AWID), .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWLEN(M_AXI_AWLEN),
        .M_AXI_AWSIZE(M_AXI_AWSIZE), .M_AXI_AWBURST(M_AXI_AWBURST), .M_AXI_AWLOCK(M_AXI_AWLOCK),
        .M_AXI_AWCACHE(M_AXI_AWCACHE), .M_AXI_AWPROT(M_AXI_AWPROT), .M_AXI_AWQOS(M_AXI_AWQOS),
        .M_AXI_AWVALID(M_AXI_AWVALID), .M_AXI_AWREADY(M_AXI_AWREADY),
        .M_AXI_WDATA(M_AXI_WDATA), .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WLAST(M_AXI_WLAST),
        .M_AXI_WVALID(M_AXI_WVALID), .M_AXI_WREADY(M_AXI_WREADY),
        .M_AXI_BID(M_AXI_BID), .M_AXI_BRESP(M_AXI_BRESP), .M_AXI_BVALID(M_AXI_BVALID),
        .M_AXI_BREADY(M_AXI_BREADY)
    );

    int vectors     = 0;
    int miscompares = 0;

    logic [127:0] wd [8];
    logic [15:0]  ws [8];
    logic [63:0]  od [16];
    logic [7:0]   os [16];
    logic         ol [16];
    int           n_obs;
    logic         saw_master;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the AW handshake.
    task automatic aw_send(input logic [3:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] size);
        int n;
        n = 0;
        S_AXI_AWID = id;   S_AXI_AWADDR = addr; S_AXI_AWLEN = len; S_AXI_AWSIZE = size;
        S_AXI_AWBURST = 2'b01; S_AXI_AWLOCK = 1'b1; S_AXI_AWCACHE = 4'h3;
        S_AXI_AWPROT = 3'h2;   S_AXI_AWQOS = 4'hA;  S_AXI_AWVALID = 1'b1;
        #1;
        while (!S_AXI_AWREADY && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        chk("aw_accept", S_AXI_AWREADY, 1'b1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0;
    endtask

    task automatic m_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int n;
        n = 0;
        #1;
        while (!M_AXI_AWVALID && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        chk("m_awvalid", M_AXI_AWVALID, 1'b1);
        chk("m_awid", M_AXI_AWID, id);
        chk("m_awaddr", M_AXI_AWADDR, addr);
        chk("m_awlen", M_AXI_AWLEN, len);
        chk("m_awsize", M_AXI_AWSIZE, 3'd3);
        chk("m_awburst", M_AXI_AWBURST, 2'b01);
        chk("m_sideband", {M_AXI_AWLOCK, M_AXI_AWCACHE, M_AXI_AWPROT, M_AXI_AWQOS},
            {1'b1, 4'h3, 3'h2, 4'hA});
        chk("s_wready_before_data", S_AXI_WREADY, 1'b0);
        M_AXI_AWREADY = 1'b1;
        @(negedge ACLK);
        M_AXI_AWREADY = 1'b0;
    endtask

    // Drives n wide beats from wd/ws and collects narrow beats until en have been seen.
    task automatic run_w(input int n, input int en, input bit toggle);
        int sp;
        int cyc;
        sp = 0;
        cyc = 0;
        n_obs = 0;
        saw_master = 1'b0;
        while (!(sp == n && n_obs == en) && cyc < 300) begin
            S_AXI_WVALID = (sp < n);
            S_AXI_WDATA  = (sp < n) ? wd[sp] : '0;
            S_AXI_WSTRB  = (sp < n) ? ws[sp] : '0;
            S_AXI_WLAST  = (sp == n - 1);
            M_AXI_WREADY = toggle ? cyc[0] : 1'b1;
            #1;
            if (M_AXI_AWVALID || M_AXI_WVALID) saw_master = 1'b1;
            if (S_AXI_WVALID && S_AXI_WREADY) sp++;
            if (M_AXI_WVALID && M_AXI_WREADY && n_obs < 16) begin
                od[n_obs] = M_AXI_WDATA;
                os[n_obs] = M_AXI_WSTRB;
                ol[n_obs] = M_AXI_WLAST;
                n_obs++;
            end
            @(negedge ACLK);
            cyc++;
        end
        S_AXI_WVALID = 1'b0;
        S_AXI_WLAST  = 1'b0;
        M_AXI_WREADY = 1'b0;
        chk("w_phase_done", (sp == n && n_obs == en), 1'b1);
    endtask

    task automatic b_ok(input logic [3:0] id, input int hold);
        int n;
        logic held_ok;
        n = 0;
        held_ok = 1'b1;
        #1;
        chk("m_wvalid_after_last", M_AXI_WVALID, 1'b0);
        M_AXI_BVALID = 1'b1; M_AXI_BID = id; M_AXI_BRESP = 2'b00; S_AXI_BREADY = 1'b0;
        #1;
        while (!S_AXI_BVALID && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        chk("s_bvalid", S_AXI_BVALID, 1'b1);
        chk("s_bid", S_AXI_BID, id);
        chk("s_bresp", S_AXI_BRESP, 2'b00);
        for (int i = 0; i < hold; i++) begin
            if (M_AXI_BREADY !== 1'b0 || S_AXI_BVALID !== 1'b1) held_ok = 1'b0;
            @(negedge ACLK); #1;
        end
        if (hold > 0) chk("b_backpressure_hold", held_ok, 1'b1);
        S_AXI_BREADY = 1'b1;
        #1;
        chk("m_bready", M_AXI_BREADY, 1'b1);
        @(negedge ACLK);
        M_AXI_BVALID = 1'b0; S_AXI_BREADY = 1'b0;
        #1;
        chk("awready_after_b", S_AXI_AWREADY, 1'b1);
    endtask

    task automatic b_err(input logic [3:0] id);
        int n;
        n = 0;
        #1;
        while (!S_AXI_BVALID && n < 50) begin
            @(negedge ACLK); #1; n++;
        end
        chk("err_bvalid", S_AXI_BVALID, 1'b1);
        chk("err_bid", S_AXI_BID, id);
        chk("err_bresp", S_AXI_BRESP, 2'b10);
        S_AXI_BREADY = 1'b1;
        #1;
        chk("err_m_bready", M_AXI_BREADY, 1'b0);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
        #1;
        chk("awready_after_err", S_AXI_AWREADY, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETN = 1'b0;
        S_AXI_AWID = '0; S_AXI_AWADDR = '0; S_AXI_AWLEN = '0; S_AXI_AWSIZE = '0;
        S_AXI_AWBURST = '0; S_AXI_AWLOCK = 1'b0; S_AXI_AWCACHE = '0; S_AXI_AWPROT = '0;
        S_AXI_AWQOS = '0; S_AXI_AWVALID = 1'b0; S_AXI_WDATA = '0; S_AXI_WSTRB = '0;
        S_AXI_WLAST = 1'b0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        M_AXI_AWREADY = 1'b0; M_AXI_WREADY = 1'b0; M_AXI_BID = '0; M_AXI_BRESP = '0;
        M_AXI_BVALID = 1'b0;

        // Reset state
        repeat (2) @(negedge ACLK);
        #1;
        chk("rst_handshake", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                              M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 6'b0);
        chk("rst_m_awlen", M_AXI_AWLEN, 8'h00);
        chk("rst_m_awsize", M_AXI_AWSIZE, 3'd0);
        chk("rst_m_wdata", M_AXI_WDATA, 64'h0);
        @(negedge ACLK);
        ARESETN = 1'b1;

        // Single wide beat
        wd[0] = {64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222};
        ws[0] = 16'hFFFF;
        aw_send(4'h5, 32'h0000_1000, 8'd0, 3'd4);
        m_aw(4'h5, 32'h0000_1000, 8'd1);
        run_w(1, 2, 1'b0);
        chk("t1_d0", od[0], 64'h2222_2222_2222_2222);
        chk("t1_d1", od[1], 64'h1111_1111_1111_1111);
        chk("t1_last0", ol[0], 1'b0);
        chk("t1_last1", ol[1], 1'b1);
        chk("t1_strb", {os[0], os[1]}, 16'hFFFF);
        b_ok(4'h5, 0);

        // Four wide beats, master WREADY toggling
        for (int i = 0; i < 4; i++) begin
            wd[i] = {64'hC0DE_0000_0000_0000 + 64'(2 * i + 1), 64'hC0DE_0000_0000_0000 + 64'(2 * i)};
            ws[i] = 16'hFFFF;
        end
        @(negedge ACLK);
        aw_send(4'h3, 32'h0000_2000, 8'd3, 3'd4);
        m_aw(4'h3, 32'h0000_2000, 8'd7);
        run_w(4, 8, 1'b1);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("t2_d%0d", k), od[k], 64'hC0DE_0000_0000_0000 + 64'(k));
            chk($sformatf("t2_last%0d", k), ol[k], (k == 7));
        end
        b_ok(4'h3, 0);

        // Upper halves with all-zero strobes are still emitted
        wd[0] = {64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
        wd[1] = {64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666};
        ws[0] = 16'h00FF;
        ws[1] = 16'h00FF;
        @(negedge ACLK);
        aw_send(4'h9, 32'h0000_3000, 8'd1, 3'd4);
        m_aw(4'h9, 32'h0000_3000, 8'd3);
        run_w(2, 4, 1'b0);
        chk("t3_strb", {os[0], os[1], os[2], os[3]}, 32'hFF00_FF00);
        chk("t3_d1", od[1], 64'h3333_3333_3333_3333);
        chk("t3_d3", od[3], 64'h5555_5555_5555_5555);
        chk("t3_last3", ol[3], 1'b1);
        b_ok(4'h9, 0);

        // Illegal size -> drained, SLVERR
        @(negedge ACLK);
        aw_send(4'h6, 32'h0000_4000, 8'd1, 3'd3);
        #1;
        chk("t4_drain_wready", S_AXI_WREADY, 1'b1);
        run_w(2, 0, 1'b0);
        chk("t4_no_master", saw_master, 1'b0);
        b_err(4'h6);

        // Illegal length -> drained, SLVERR
        @(negedge ACLK);
        aw_send(4'hC, 32'h0000_5000, 8'd200, 3'd4);
        run_w(1, 0, 1'b0);
        chk("t5_no_master", saw_master, 1'b0);
        b_err(4'hC);

        // Response back-pressure for 10 cycles
        wd[0] = {64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
        ws[0] = 16'hFFFF;
        @(negedge ACLK);
        aw_send(4'h2, 32'h0000_6000, 8'd0, 3'd4);
        m_aw(4'h2, 32'h0000_6000, 8'd1);
        run_w(1, 2, 1'b0);
        chk("t6_d0", od[0], 64'h8888_8888_8888_8888);
        b_ok(4'h2, 10);

        // Reset in the middle of a burst
        @(negedge ACLK);
        aw_send(4'h7, 32'h0000_7000, 8'd1, 3'd4);
        m_aw(4'h7, 32'h0000_7000, 8'd3);
        S_AXI_WVALID = 1'b1; S_AXI_WDATA = {2{64'hDEAD_BEEF_DEAD_BEEF}};
        S_AXI_WSTRB = 16'hFFFF; S_AXI_WLAST = 1'b0; M_AXI_WREADY = 1'b0;
        @(negedge ACLK);
        S_AXI_WVALID = 1'b0;
        #1;
        chk("t7_m_wvalid_before_rst", M_AXI_WVALID, 1'b1);
        ARESETN = 1'b0;
        #1;
        chk("t7_rst_valids", {S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID,
                              M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY}, 6'b0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        wd[0] = {64'h9999_9999_9999_9999, 64'hAAAA_AAAA_AAAA_AAAA};
        ws[0] = 16'hFFFF;
        aw_send(4'h1, 32'h0000_8000, 8'd0, 3'd4);
        m_aw(4'h1, 32'h0000_8000, 8'd1);
        run_w(1, 2, 1'b0);
        chk("t7_d0", od[0], 64'hAAAA_AAAA_AAAA_AAAA);
        chk("t7_d1", od[1], 64'h9999_9999_9999_9999);
        b_ok(4'h1, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
